traffic_lane_engine: RTL and testbench

//  Parametrised obstacle engine for the frogger playfield: owns NUM_LANES x CARS_PER_LANE car

---
 rtl/traffic_lane_engine.sv | 172 +++++++++++++++++
 tb/tb_traffic_lane_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lane_engine.sv
// Obstacle engine for the frogger playfield. It moves every lane's cars once per level-dependent
// frame period, checks for frog/car collisions once per frame, and answers raster tile queries.
module traffic_lane_engine #(
    parameter int GRID_W        = 20,
    parameter int COORD_W       = 5,
    parameter int NUM_LANES     = 5,
    parameter int CARS_PER_LANE = 2,
    parameter int FIRST_ROW     = 8,
    parameter logic [NUM_LANES-1:0] LANE_DIR_MASK = 5'b10101,
    parameter int LANE_OFFSET   = 3,
    parameter int BASE_PERIOD   = 30,
    parameter int LANE_SKEW     = 3,
    parameter int SPEED_STEP    = 2,
    parameter int MIN_PERIOD    = 4
) (
    input  logic                                      i_Clk,
    input  logic                                      i_Reset,
    input  logic                                      i_Frame_Tick,
    input  logic                                      i_Enable,
    input  logic [6:0]                                i_Level,
    input  logic [COORD_W-1:0]                        i_Frog_X,
    input  logic [COORD_W-1:0]                        i_Frog_Y,
    input  logic                                      i_Clear_Hit,
    input  logic [COORD_W-1:0]                        i_Query_X,
    input  logic [COORD_W-1:0]                        i_Query_Y,
    output logic [NUM_LANES*CARS_PER_LANE*COORD_W-1:0] o_Car_X,
    output logic                                      o_Busy,
    output logic                                      o_Hit_Pulse,
    output logic                                      o_Collided,
    output logic                                      o_Query_Car
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK} state_t;

    state_t               state, state_next;
    logic [LANE_W-1:0]    lane_idx;
    logic [6:0]           level_q;
    logic                 pending;
    logic                 start_sweep, busy, hit_now, query_hit;
    logic [COORD_W-1:0]   car_x    [NUM_LANES][CARS_PER_LANE];
    logic [CNT_W-1:0]     lane_cnt [NUM_LANES];

    function automatic logic [COORD_W-1:0] init_x(input int l, input int k);
        return COORD_W'((k * GRID_W / CARS_PER_LANE + l * LANE_OFFSET) % GRID_W);
    endfunction

    // Clamp is tested before subtracting so the unsigned difference can never wrap.
    function automatic logic [CNT_W-1:0] lane_period(input int l, input logic [6:0] lvl);
        logic [CNT_W-1:0] up;
        logic [CNT_W-1:0] down;
        up   = CNT_W'(BASE_PERIOD + l * LANE_SKEW);
        down = CNT_W'(lvl) * CNT_W'(SPEED_STEP);
        if (up < down + CNT_W'(MIN_PERIOD))
            return CNT_W'(MIN_PERIOD);
        return up - down;
    endfunction

    function automatic logic [COORD_W-1:0] step_x(input logic [COORD_W-1:0] x, input logic right);
        if (right)
            return (x == COORD_W'(GRID_W - 1)) ? '0 : x + 1'b1;
        return (x == '0) ? COORD_W'(GRID_W - 1) : x - 1'b1;
    endfunction

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        start_sweep = 1'b0;
        case (state)
            IDLE: begin
                if ((i_Frame_Tick || pending) && i_Enable) begin
                    start_sweep = 1'b1;
                    state_next  = MOVE;
                end
            end
            MOVE: begin
                busy = 1'b1;
                if (lane_idx == LANE_W'(NUM_LANES - 1))
                    state_next = CHECK;
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hit_now   = 1'b0;
        query_hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < CARS_PER_LANE; k++) begin
                if (i_Frog_Y == COORD_W'(FIRST_ROW + l) && i_Frog_X == car_x[l][k])
                    hit_now = 1'b1;
                if (i_Query_Y == COORD_W'(FIRST_ROW + l) && i_Query_X == car_x[l][k])
                    query_hit = 1'b1;
            end
        end
    end

    // A counter at or beyond period-1 (possible after a level increase) counts as expiry.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            lane_idx    <= '0;
            level_q     <= '0;
            pending     <= 1'b0;
            o_Hit_Pulse <= 1'b0;
            o_Collided  <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                lane_cnt[l] <= '0;
                for (int k = 0; k < CARS_PER_LANE; k++)
                    car_x[l][k] <= init_x(l, k);
            end
        end else begin
            o_Hit_Pulse <= (state == CHECK) && hit_now;
            if ((state == CHECK) && hit_now)
                o_Collided <= 1'b1;
            else if (i_Clear_Hit)
                o_Collided <= 1'b0;

            if (start_sweep) begin
                level_q  <= i_Level;
                pending  <= 1'b0;
                lane_idx <= '0;
            end else if (busy && i_Frame_Tick && i_Enable) begin
                pending <= 1'b1;
            end

            if (state == MOVE) begin
                lane_idx <= lane_idx + 1'b1;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (lane_idx == LANE_W'(l)) begin
                        if (lane_cnt[l] >= lane_period(l, level_q) - 1'b1) begin
                            lane_cnt[l] <= '0;
                            for (int k = 0; k < CARS_PER_LANE; k++)
                                car_x[l][k] <= step_x(car_x[l][k], LANE_DIR_MASK[l]);
                        end else begin
                            lane_cnt[l] <= lane_cnt[l] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            o_Query_Car <= 1'b0;
        else
            o_Query_Car <= query_hit;
    end

    always_comb begin
        o_Car_X = '0;
        for (int l = 0; l < NUM_LANES; l++)
            for (int k = 0; k < CARS_PER_LANE; k++)
                o_Car_X[(l * CARS_PER_LANE + k) * COORD_W +: COORD_W] = car_x[l][k];
    end

    assign o_Busy = busy;

endmodule

// File: tb/tb_traffic_lane_engine.sv
// Directed bench for traffic_lane_engine: reset values, lane stepping and wrap, level clamp,
// collision pulse/sticky flag, tick pending and mid-sweep reset.
module tb_traffic_lane_engine;

    localparam int COORD_W = 5;
    localparam int NL      = 5;
    localparam int CPL     = 2;

    logic                     clk;
    logic                     rst;
    logic                     tick;
    logic                     enable;
    logic [6:0]               level;
    logic [COORD_W-1:0]       frog_x, frog_y, query_x, query_y;
    logic                     clear_hit;
    logic [NL*CPL*COORD_W-1:0] car_x_bus;
    logic                     busy, hit_pulse, collided, query_car;

    int checks = 0;
    int errors = 0;

    traffic_lane_engine dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Frame_Tick (tick),
        .i_Enable     (enable),
        .i_Level      (level),
        .i_Frog_X     (frog_x),
        .i_Frog_Y     (frog_y),
        .i_Clear_Hit  (clear_hit),
        .i_Query_X    (query_x),
        .i_Query_Y    (query_y),
        .o_Car_X      (car_x_bus),
        .o_Busy       (busy),
        .o_Hit_Pulse  (hit_pulse),
        .o_Collided   (collided),
        .o_Query_Car  (query_car)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] carX(input int l, input int k);
        return 32'(car_x_bus[(l * CPL + k) * COORD_W +: COORD_W]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkLane(input string tag, input int l, input int x0, input int x1);
        checkOutput({tag, " car0"}, carX(l, 0), 32'(x0));
        checkOutput({tag, " car1"}, carX(l, 1), 32'(x1));
    endtask

    // One frame tick; returns hit pulse at tick+7 and tick+8 and busy at tick+1, +6, +7.
    task automatic applyStimulus(input logic clr, output logic hit7, output logic hit8,
                                 output logic busy1, output logic busy6, output logic busy7);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        busy1 = busy;
        repeat (5) @(negedge clk);
        busy6     = busy;
        clear_hit = clr;
        @(negedge clk);
        clear_hit = 1'b0;
        hit7  = hit_pulse;
        busy7 = busy;
        @(negedge clk);
        hit8 = hit_pulse;
    endtask

    task automatic runTicks(input int n);
        logic h7, h8, b1, b6, b7;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, h7, h8, b1, b6, b7);
    endtask

    task automatic resetDut();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic countSweeps(input int gap_ticks, output int rises);
        logic prev;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        for (int i = 1; i < gap_ticks; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
        rises = 1;
        prev  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy && !prev)
                rises++;
            prev = busy;
        end
    endtask

    initial begin
        logic h7, h8, b1, b6, b7;
        int   sweeps;

        rst       = 1'b1;
        tick      = 1'b0;
        enable    = 1'b1;
        level     = 7'd0;
        frog_x    = '0;
        frog_y    = '0;
        clear_hit = 1'b0;
        query_x   = '0;
        query_y   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkLane("reset lane0", 0, 0, 10);
        checkLane("reset lane1", 1, 3, 13);
        checkLane("reset lane4", 4, 12, 2);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset collided", 32'(collided), 32'd0);
        checkOutput("reset hit", 32'(hit_pulse), 32'd0);

        query_x = 5'd10; query_y = 5'd8;
        @(negedge clk) checkOutput("query lane0 car", 32'(query_car), 32'd1);
        query_x = 5'd10; query_y = 5'd9;
        @(negedge clk) checkOutput("query lane1 empty", 32'(query_car), 32'd0);
        query_x = 5'd13; query_y = 5'd9;
        @(negedge clk) checkOutput("query lane1 car", 32'(query_car), 32'd1);
        query_x = 5'd0; query_y = 5'd7;
        @(negedge clk) checkOutput("query off-lane row", 32'(query_car), 32'd0);

        // Level 0: lane0 period 30, lane1 period 33
        runTicks(29);
        checkLane("lvl0 tick29 lane0", 0, 0, 10);
        applyStimulus(1'b0, h7, h8, b1, b6, b7);
        checkLane("lvl0 tick30 lane0", 0, 1, 11);
        checkLane("lvl0 tick30 lane1", 1, 3, 13);
        checkOutput("busy tick+1", 32'(b1), 32'd1);
        checkOutput("busy tick+6", 32'(b6), 32'd1);
        checkOutput("busy tick+7", 32'(b7), 32'd0);

        enable = 1'b0;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        checkOutput("disabled tick busy", 32'(busy), 32'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("disabled tick not pended", 32'(busy), 32'd0);

        // Level 20 clamps every lane to period 4
        resetDut();
        level  = 7'd20;
        frog_x = 5'd1;
        frog_y = 5'd8;
        runTicks(2);
        applyStimulus(1'b0, h7, h8, b1, b6, b7);
        checkOutput("no hit before step", 32'(h7), 32'd0);
        checkLane("lvl20 tick3 lane0", 0, 0, 10);
        applyStimulus(1'b0, h7, h8, b1, b6, b7);
        checkOutput("hit pulse tick+7", 32'(h7), 32'd1);
        checkOutput("hit pulse tick+8", 32'(h8), 32'd0);
        checkOutput("collided set", 32'(collided), 32'd1);
        checkLane("lvl20 tick4 lane0", 0, 1, 11);
        checkLane("lvl20 tick4 lane1", 1, 2, 12);
        applyStimulus(1'b1, h7, h8, b1, b6, b7);
        checkOutput("hit again tick5", 32'(h7), 32'd1);
        checkOutput("clear loses to hit", 32'(collided), 32'd1);
        frog_y = 5'd7;
        applyStimulus(1'b0, h7, h8, b1, b6, b7);
        checkOutput("off-lane frog no hit", 32'(h7), 32'd0);
        checkOutput("collided sticky", 32'(collided), 32'd1);
        @(negedge clk) clear_hit = 1'b1;
        @(negedge clk) clear_hit = 1'b0;
        checkOutput("collided cleared", 32'(collided), 32'd0);

        runTicks(10);
        checkLane("tick16 lane0", 0, 4, 14);
        checkLane("tick16 lane1 wrap", 1, 19, 9);
        runTicks(20);
        checkLane("tick36 lane0", 0, 9, 19);
        checkLane("tick36 lane1", 1, 14, 4);
        runTicks(4);
        checkLane("tick40 lane0 wrap", 0, 10, 0);
        checkLane("tick40 lane1", 1, 13, 3);

        countSweeps(2, sweeps);
        checkOutput("two ticks two sweeps", 32'(sweeps), 32'd2);
        countSweeps(3, sweeps);
        checkOutput("three ticks two sweeps", 32'(sweeps), 32'd2);
        checkLane("tick44 lane0", 0, 11, 1);

        frog_y = 5'd8;
        applyStimulus(1'b0, h7, h8, b1, b6, b7);
        checkOutput("collided before reset", 32'(collided), 32'd1);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        checkOutput("midsweep reset busy", 32'(busy), 32'd0);
        checkOutput("midsweep reset collided", 32'(collided), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkLane("midsweep reset lane0", 0, 0, 10);
        checkLane("midsweep reset lane1", 1, 3, 13);
        checkOutput("post reset busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
